// File: rtl/lc4_wb_buffer_ss.sv
// ---------------------------------------------------------------------------
// lc4_wb_buffer_ss
// Write-back buffer between a two-wide pipeline (pipes A and B) and a
// dual-write register file. Results are queued in program order (A before B)
// and drained up to two per cycle: the oldest entry on port A and the
// second-oldest on port B. The register file gives port B priority on a
// same-register collision, so the younger value wins.
//
// Ports
//   clk, rst (sync, active-low), gwe (global write enable: gates every
//   state change, reset included)
//   i_enq_valid_A/B, i_enq_rd_A/B, i_enq_data_A/B : results to enqueue
//   o_enq_ready                                   : two free slots this cycle
//   i_wb_en                                       : register file may be written
//   o_rd_A/o_wdata_A/o_rd_we_A                    : write port A (head entry)
//   o_rd_B/o_wdata_B/o_rd_we_B                    : write port B (head+1 entry)
//   i_lookup_rs, o_lookup_hit, o_lookup_data      : youngest pending value
//   o_count                                       : occupied entries
//
// Handshake: a result is accepted on a posedge where gwe=1, rst=1,
// o_enq_ready=1 and its valid is high. o_enq_ready depends only on the
// registered count, so the producer holds its valids until it sees ready.
// ---------------------------------------------------------------------------
module lc4_wb_buffer_ss #(
  parameter int n     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gwe,
  input  logic                     i_enq_valid_A,
  input  logic                     i_enq_valid_B,
  input  logic [2:0]               i_enq_rd_A,
  input  logic [2:0]               i_enq_rd_B,
  input  logic [n-1:0]             i_enq_data_A,
  input  logic [n-1:0]             i_enq_data_B,
  output logic                     o_enq_ready,
  input  logic                     i_wb_en,
  output logic [2:0]               o_rd_A,
  output logic [n-1:0]             o_wdata_A,
  output logic                     o_rd_we_A,
  output logic [2:0]               o_rd_B,
  output logic [n-1:0]             o_wdata_B,
  output logic                     o_rd_we_B,
  input  logic [2:0]               i_lookup_rs,
  output logic                     o_lookup_hit,
  output logic [n-1:0]             o_lookup_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    rd_mem   [DEPTH];
  logic [n-1:0]  data_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic [CW-1:0] enq_n;
  logic [CW-1:0] deq_n;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_b;
  logic          enq_ready;

  assign enq_ready = (count <= CW'(DEPTH - 2));
  assign head_p1   = head + AW'(1);
  // B lands right after A, or at the tail itself when A is absent.
  assign tail_b    = i_enq_valid_A ? (tail + AW'(1)) : tail;

  always_comb begin
    enq_n = '0;
    if (enq_ready)
      enq_n = CW'(i_enq_valid_A) + CW'(i_enq_valid_B);
  end

  always_comb begin
    deq_n = '0;
    if (i_wb_en)
      deq_n = (count >= CW'(2)) ? CW'(2) : count;
  end

  // DEPTH is a power of two, so the low AW bits of the step give the
  // modulo-DEPTH pointer advance (a step of 2 with DEPTH=2 wraps to 0).
  always_ff @(posedge clk) begin
    if (gwe) begin
      if (!rst) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq_ready && i_enq_valid_A) begin
          rd_mem[tail]   <= i_enq_rd_A;
          data_mem[tail] <= i_enq_data_A;
        end
        if (enq_ready && i_enq_valid_B) begin
          rd_mem[tail_b]   <= i_enq_rd_B;
          data_mem[tail_b] <= i_enq_data_B;
        end
        head  <= head + deq_n[AW-1:0];
        tail  <= tail + enq_n[AW-1:0];
        count <= count + enq_n - deq_n;
      end
    end
  end

  assign o_enq_ready = enq_ready;
  assign o_count     = count;
  assign o_rd_A      = rd_mem[head];
  assign o_wdata_A   = data_mem[head];
  assign o_rd_we_A   = i_wb_en & (count != '0);
  assign o_rd_B      = rd_mem[head_p1];
  assign o_wdata_B   = data_mem[head_p1];
  assign o_rd_we_B   = i_wb_en & (count >= CW'(2));

  // Walk occupied entries oldest to youngest; the last match is the youngest.
  logic [AW-1:0] lk_idx;
  always_comb begin
    o_lookup_hit  = 1'b0;
    o_lookup_data = '0;
    lk_idx        = head;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head + AW'(i);
      if ((CW'(i) < count) && (rd_mem[lk_idx] == i_lookup_rs)) begin
        o_lookup_hit  = 1'b1;
        o_lookup_data = data_mem[lk_idx];
      end
    end
  end

endmodule
